imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_pkg.sv | 13 +
 rtl/imm_gen_pipe_if.sv | 26 ++
 rtl/imm_decode.sv | 42 ++++
 rtl/imm_gen_pipe.sv | 111 +++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: format select codes and default datapath width.
package imm_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_CSR = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: upstream instruction side, flush, downstream immediate side.
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [2:0]      in_immsrc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_immsrc, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_immsrc, flush, out_ready,
        output in_ready, out_valid, out_imm, out_illegal
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction and sign extension to XLEN.
// Code 101 (CSR uimm) is decoded only when IMM_GEN_ZICSR_EN is defined.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] imm32_s;
    logic        unused_opcode_s;

    assign unused_opcode_s = ^instr[6:0];

    // Build the 32-bit immediate; every legal format is already sign-correct at bit 31.
    always_comb begin
        imm32_s = 32'd0;
        illegal = 1'b0;
        case (immsrc)
            IMM_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32_s = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm32_s = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm32_s = {instr[31:12], 12'd0};
`ifdef IMM_GEN_ZICSR_EN
            IMM_CSR: imm32_s = {27'd0, instr[19:15]};
`endif
            default: begin
                imm32_s = 32'd0;
                illegal = 1'b1;
            end
        endcase
    end

    // CSR uimm has bit 31 clear, so sign extension doubles as its zero extension.
    assign imm = XLEN'(signed'(imm32_s));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry (main + skid) buffer and valid/ready handshake.
// Optional CSR uimm format enabled by IMM_GEN_ZICSR_EN (see imm_decode).
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_immsrc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm_s;
    logic            dec_ill_s;
    logic            in_fire_s;
    logic            out_fire_s;
    logic            main_free_s;

    logic            main_valid_q, main_valid_d;
    logic [XLEN-1:0] main_imm_q,   main_imm_d;
    logic            main_ill_q,   main_ill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    logic            skid_ill_q,   skid_ill_d;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .immsrc  (in_immsrc),
        .imm     (dec_imm_s),
        .illegal (dec_ill_s)
    );

    // in_ready depends only on skid state, keeping out_ready off the upstream path.
    assign in_fire_s   = in_valid && !skid_valid_q;
    assign out_fire_s  = main_valid_q && out_ready;
    assign main_free_s = !main_valid_q || out_fire_s;

    // Next-state for main/skid: skid refills main first, new data lands behind it.
    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_ill_d   = main_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free_s) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_ill_d   = skid_ill_q;
                skid_valid_d = in_fire_s;
                if (in_fire_s) begin
                    skid_imm_d = dec_imm_s;
                    skid_ill_d = dec_ill_s;
                end else begin
                    skid_imm_d = skid_imm_q;
                end
            end else begin
                main_valid_d = in_fire_s;
                if (in_fire_s) begin
                    main_imm_d = dec_imm_s;
                    main_ill_d = dec_ill_s;
                end else begin
                    main_imm_d = main_imm_q;
                end
            end
        end else if (in_fire_s) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm_s;
            skid_ill_d   = dec_ill_s;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // Buffer state registers; reset empties both entries and zeroes the visible outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= {XLEN{1'b0}};
            main_ill_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= {XLEN{1'b0}};
            skid_ill_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_ill_q   <= main_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_imm     = main_imm_q;
    assign out_illegal = main_ill_q;

endmodule
